// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between icache and dcache. The dcache is granted two-word
// blocks and a starve counter protects the icache. Optional stats counters: MEM_ARBITER_STATS_EN.
module mem_arbiter #(
    parameter int STARVE_MAX = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount
`endif
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_beat;
    logic        w_nextBeat;
    logic [1:0]  r_starve;
    logic [1:0]  w_nextStarve;
    logic        w_dReq;
    logic        w_access;
    logic        w_starved;

    assign w_dReq    = dREN | dWEN;
    assign w_access  = (ramstate == RAM_ACCESS);
    assign w_starved = (int'(r_starve) >= STARVE_MAX);

    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_beat   <= 1'b0;
            r_starve <= 2'd0;
        end else begin
            r_state  <= w_nextState;
            r_beat   <= w_nextBeat;
            r_starve <= w_nextStarve;
        end
    end

    // The dcache yields only when the icache is actually waiting and has been
    // passed over often enough; a stale starve count alone never blocks the dcache.
    always_comb begin
        w_nextState  = r_state;
        w_nextBeat   = r_beat;
        w_nextStarve = r_starve;
        case (r_state)
            IDLE: begin
                if (w_dReq && !(w_starved && iREN)) begin
                    w_nextState = DGRANT;
                end else if (iREN) begin
                    w_nextState  = IGRANT;
                    w_nextStarve = 2'd0;
                end
            end
            DGRANT: begin
                if (!w_dReq) begin
                    w_nextState = IDLE;
                    w_nextBeat  = 1'b0;
                end else if (w_access) begin
                    if (r_beat) begin
                        w_nextState = IDLE;
                        w_nextBeat  = 1'b0;
                        if (iREN && (r_starve != 2'b11)) begin
                            w_nextStarve = r_starve + 2'd1;
                        end
                    end else begin
                        w_nextBeat = 1'b1;
                    end
                end
            end
            IGRANT: begin
                if (!iREN || w_access) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Only the owner ever sees wait low; a dropped request produces no strobe.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (r_state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~(w_access & w_dReq);
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~(w_access & iREN);
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] r_icount;
    logic [31:0] r_dcount;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_icount <= 32'd0;
            r_dcount <= 32'd0;
        end else begin
            if ((r_state == IGRANT) && iREN && w_access) begin
                r_icount <= r_icount + 32'd1;
            end
            if ((r_state == DGRANT) && w_dReq && w_access) begin
                r_dcount <= r_dcount + 32'd1;
            end
        end
    end

    assign icount = r_icount;
    assign dcount = r_dcount;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
 - CLK  in  1  system clock, rising edge.
 - nRST  in  1  asynchronous, active-low reset.
 - iREN  in  1  icache read request.
 - iaddr  in  32  icache word address.
 - iwait  out  1  icache stall; 0 only on the completing cycle.
 - iload  out  32  icache read data.
 - dREN  in  1  dcache read request.
 - dWEN  in  1  dcache write request.
 - daddr  in  32  dcache word address.
 - dstore  in  32  dcache write data.
 - dwait  out  1  dcache stall; 0 only on the completing cycle.
 - dload  out  32  dcache read data.
 - ramREN  out  1  memory read strobe.
 - ramWEN  out  1  memory write strobe.
 - ramaddr  out  32  memory address.
 - ramstore  out  32  memory write data.
 - ramload  in  32  memory read data.
 - ramstate  in  2  memory status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-002 The parameter STARVE_MAX, default 2, SHALL set the number of consecutive dcache blocks tolerated while iREN is pending.

Function
REQ-003 The FSM SHALL have three states: IDLE, DGRANT and IGRANT.
REQ-004 IDLE: ram strobes 0, ramaddr/ramstore 0, iwait=dwait=1; no memory access issued.
REQ-005 IDLE arbitration, decided at the clock edge (1-cycle arbitration latency):
 - (dREN|dWEN) and starve<STARVE_MAX -> DGRANT.
 - else iREN -> IGRANT.
 - else stay in IDLE.
REQ-006 DGRANT SHALL drive ramaddr=daddr and ramstore=dstore.
REQ-007 In DGRANT, ramWEN=dWEN and ramREN=dREN&~dWEN; write wins if both are asserted.
REQ-008 IGRANT SHALL drive ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
REQ-009 The granted requester's wait SHALL be 0 exactly when ramstate==ACCESS; the non-granted requester's wait SHALL be 1.
REQ-010 dload and iload SHALL both equal ramload combinationally at all times; validity is qualified by the requester's wait.
REQ-011 DGRANT SHALL hold for one two-word block, tracked by a 1-bit beat counter:
 - ACCESS with beat=0 -> beat=1, stay in DGRANT.
 - ACCESS with beat=1 -> IDLE, beat cleared.
REQ-012 IGRANT SHALL return to IDLE after one ACCESS cycle.
REQ-013 If the owner drops its request while granted, the FSM SHALL return to IDLE next cycle, clear beat, and issue no ram strobe that cycle.
REQ-014 BUSY and FREE while granted SHALL hold state with the owner's wait=1.
REQ-015 ERROR SHALL be treated as BUSY: hold, wait=1, beat unchanged.
REQ-016 The starve counter (2 bits, saturating) SHALL increment on each DGRANT block completion while iREN=1, and clear on entry to IGRANT.
REQ-017 When starve>=STARVE_MAX and iREN=1, IDLE SHALL grant IGRANT even if the dcache is requesting.
REQ-018 Back-to-back requests SHALL cost exactly one IDLE cycle between grants.

Reset
REQ-019 Asserting nRST SHALL asynchronously force state=IDLE and beat=0, starve=0, and all stats counters to 0.
REQ-020 Outputs during reset SHALL be the IDLE values of REQ-004.
REQ-021 Reset mid-grant SHALL abort the transfer; no strobe is asserted until re-arbitration after release.

Configuration
REQ-022 Macro MEM_ARBITER_STATS_EN, when defined, SHALL add two outputs:
 - icount  out  32  counts completed icache ACCESS cycles.
 - dcount  out  32  counts completed dcache ACCESS cycles.
 - Both wrap from 0xFFFFFFFF to 0 and are reset to 0.
REQ-023 When MEM_ARBITER_STATS_EN is undefined, these ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-024 iREN=1, iaddr=0x40, ramstate ACCESS on 2nd grant cycle, ramload=0xDEADBEEF -> iwait=0 for one cycle with iload=0xDEADBEEF, then IDLE.
REQ-025 dWEN=dREN=1, daddr=0x100/0x104, dstore=0x11/0x22 -> ramWEN=1, ramREN=0, two ACCESS beats, dwait low twice, then IDLE.
REQ-026 iREN and dREN asserted together from IDLE -> DGRANT first; iwait stays 1 until the dcache block completes plus one IDLE cycle.
REQ-027 iREN held, dcache issues three back-to-back blocks, STARVE_MAX=2 -> third arbitration grants IGRANT and starve returns to 0.
REQ-028 ramstate=ERROR for 3 cycles mid-DGRANT, then ACCESS -> dwait=1 throughout ERROR, beat unchanged, block completes normally.
REQ-029 nRST pulsed low during DGRANT beat 1 -> outputs immediately at IDLE values, counters 0 (with STATS_EN), clean re-arbitration afterwards.
